// File: rtl/wb_sram_pkg.sv
// Shared definitions for the wb_* Wishbone-like slaves.
//
// Contents:
//   BYTE_W          - width of one byte lane
//   MAX_LANES_LOG2  - largest supported log2(lanes per word)
//   MAX_LANES       - lane count matching MAX_LANES_LOG2
//   burst_state_e   - burst tracking state used by the port controllers
//   lane_selected() - tests whether a given lane is enabled in a lane mask
package wb_sram_pkg;

  localparam int BYTE_W         = 8;
  localparam int MAX_LANES_LOG2 = 6;
  localparam int MAX_LANES      = 1 << MAX_LANES_LOG2;

  // BURST_RUN means the previous accept had bst high, so the next transfer
  // takes its address from the internal counter instead of adr.
  typedef enum logic {
    BURST_IDLE = 1'b0,
    BURST_RUN  = 1'b1
  } burst_state_e;

  // The mask is zero-extended by the caller to MAX_LANES bits so one helper
  // serves every lane configuration.
  function automatic logic lane_selected(input logic [MAX_LANES-1:0]      sel,
                                         input logic [MAX_LANES_LOG2-1:0] lane);
    return sel[lane];
  endfunction

endpackage

// File: rtl/wb_sram_port_ctrl.sv
// Per-port transfer control for wb_sram_asym_dp.
//
// Decides when a transfer is accepted, supplies the effective address
// (external address or burst counter) and produces the one-cycle ack.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cyc, stb    - bus cycle / strobe
//   stall       - stall returned to the master this cycle
//   bst         - burst: more transfers follow this accept
//   adr         - external address (ignored while a burst is running)
//   accept      - transfer accepted at the coming clock edge
//   eff_adr     - address used by the accepted transfer
//   ack         - registered acknowledge, one cycle after accept
module wb_sram_port_ctrl
  import wb_sram_pkg::*;
#(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cyc,
  input  logic              stb,
  input  logic              stall,
  input  logic              bst,
  input  logic [AWIDTH-1:0] adr,
  output logic              accept,
  output logic [AWIDTH-1:0] eff_adr,
  output logic              ack
);

  burst_state_e      state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  assign accept  = cyc & stb & ~stall;
  assign eff_adr = (state_q == BURST_RUN) ? cnt_q : adr;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!cyc) begin
      state_d = BURST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = bst ? BURST_RUN : BURST_IDLE;
      // Natural overflow gives the required wrap from all-ones to zero.
      cnt_d   = eff_adr + AWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      state_q <= BURST_IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= accept;
    end
  end

endmodule

// File: rtl/wb_sram_asym_dp.sv
// Asymmetric dual-port SRAM with two pipelined Wishbone-like slave ports.
//
// Port A is 8<<LANES_LOG2 bits wide with byte-lane write selects; port B is
// 8 bits wide and byte addressed. Both share one clock and one storage.
// Reads are read-first with one cycle of latency. When both ports write the
// same byte in the same cycle, A wins and B is stalled for that cycle.
//
// Optional feature macro: WB_SRAM_ASYM_BYPASS_EN
//   defined     - a read of a word the other port writes in the same cycle
//                 returns the new bytes merged with the unwritten old ones
//   not defined - such a read returns the pre-write contents
//
// Parameters: ABITS (A word-address width), LANES_LOG2 (log2 lanes per word),
//             DELAY (accepted for compatibility, not applied)
// Ports:
//   clk_i, rst_ni                           - clock, async active-low reset
//   a_cyc_i, a_stb_i, a_we_i, a_bst_i       - port A controls
//   a_sel_i, a_adr_i, a_dat_i               - port A lane enables/address/data
//   a_ack_o, a_stall_o, a_dat_o             - port A responses
//   b_cyc_i, b_stb_i, b_we_i, b_bst_i       - port B controls
//   b_adr_i, b_dat_i                        - port B byte address/data
//   b_ack_o, b_stall_o, b_dat_o             - port B responses
module wb_sram_asym_dp
  import wb_sram_pkg::*;
#(
  parameter int ABITS      = 10,
  parameter int LANES_LOG2 = 2,
  parameter int DELAY      = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               a_cyc_i,
  input  logic                               a_stb_i,
  input  logic                               a_we_i,
  input  logic                               a_bst_i,
  input  logic [(1<<LANES_LOG2)-1:0]         a_sel_i,
  input  logic [ABITS-1:0]                   a_adr_i,
  input  logic [(BYTE_W<<LANES_LOG2)-1:0]    a_dat_i,
  output logic                               a_ack_o,
  output logic                               a_stall_o,
  output logic [(BYTE_W<<LANES_LOG2)-1:0]    a_dat_o,
  input  logic                               b_cyc_i,
  input  logic                               b_stb_i,
  input  logic                               b_we_i,
  input  logic                               b_bst_i,
  input  logic [ABITS+LANES_LOG2-1:0]        b_adr_i,
  input  logic [BYTE_W-1:0]                  b_dat_i,
  output logic                               b_ack_o,
  output logic                               b_stall_o,
  output logic [BYTE_W-1:0]                  b_dat_o
);

  localparam int LANES = 1 << LANES_LOG2;
  localparam int AW    = BYTE_W * LANES;
  localparam int BW    = ABITS + LANES_LOG2;
  localparam int DEPTH = 1 << ABITS;

  // DELAY only shaped simulation timing in the predecessor; it has no
  // meaning in synthesizable logic and is kept so existing instances build.
  logic [31:0] unused_delay;
  assign unused_delay = 32'(DELAY);

  logic                  a_acc, b_acc;
  logic [ABITS-1:0]      a_word;
  logic [BW-1:0]         b_eff;
  logic [ABITS-1:0]      b_word;
  logic [LANES_LOG2-1:0] b_lane;
  logic                  a_wr, b_wr;

  assign b_word    = b_eff[BW-1:LANES_LOG2];
  assign b_lane    = b_eff[LANES_LOG2-1:0];
  assign a_wr      = a_acc & a_we_i;
  assign b_wr      = b_acc & b_we_i;
  assign a_stall_o = 1'b0;

  // Same byte targeted by two writes: A has priority. Built from effective
  // addresses and request inputs only, never from ack.
  assign b_stall_o = a_cyc_i & a_stb_i & a_we_i &
                     b_cyc_i & b_stb_i & b_we_i &
                     (a_word == b_word) &
                     lane_selected(MAX_LANES'(a_sel_i), MAX_LANES_LOG2'(b_lane));

  wb_sram_port_ctrl #(.AWIDTH(ABITS)) u_ctrl_a (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .cyc     (a_cyc_i),
    .stb     (a_stb_i),
    .stall   (1'b0),
    .bst     (a_bst_i),
    .adr     (a_adr_i),
    .accept  (a_acc),
    .eff_adr (a_word),
    .ack     (a_ack_o)
  );

  wb_sram_port_ctrl #(.AWIDTH(BW)) u_ctrl_b (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .cyc     (b_cyc_i),
    .stb     (b_stb_i),
    .stall   (b_stall_o),
    .bst     (b_bst_i),
    .adr     (b_adr_i),
    .accept  (b_acc),
    .eff_adr (b_eff),
    .ack     (b_ack_o)
  );

  logic [BYTE_W-1:0] a_rd [LANES];
  logic [BYTE_W-1:0] b_rd [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BYTE_W-1:0] mem [DEPTH];
    logic              a_lane_wr, b_lane_wr;
    logic [BYTE_W-1:0] a_old, b_old;

    assign a_lane_wr = a_wr & a_sel_i[l];
    assign b_lane_wr = b_wr & (b_lane == LANES_LOG2'(l));

    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into flops, and its contents are defined by writes, not by reset.
    // The collision stall guarantees both writes never hit the same entry.
    always_ff @(posedge clk_i) begin
      if (a_lane_wr) mem[a_word] <= a_dat_i[l*BYTE_W +: BYTE_W];
      if (b_lane_wr) mem[b_word] <= b_dat_i;
    end

    assign a_old = mem[a_word];
    assign b_old = mem[b_word];

`ifdef WB_SRAM_ASYM_BYPASS_EN
    // Forward only the byte the other port writes; same-port writes stay
    // read-first.
    assign a_rd[l] = (b_lane_wr && (b_word == a_word)) ? b_dat_i : a_old;
    assign b_rd[l] = (a_lane_wr && (a_word == b_word)) ?
                     a_dat_i[l*BYTE_W +: BYTE_W] : b_old;
`else
    assign a_rd[l] = a_old;
    assign b_rd[l] = b_old;
`endif
  end

  logic [AW-1:0] a_rd_word;

  always_comb begin
    a_rd_word = '0;
    for (int l = 0; l < LANES; l++) begin
      a_rd_word[l*BYTE_W +: BYTE_W] = a_rd[l];
    end
  end

  // Read data updates only on accept so it stays stable alongside ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_dat_o <= '0;
      b_dat_o <= '0;
    end else begin
      if (a_acc) a_dat_o <= a_rd_word;
      if (b_acc) b_dat_o <= b_rd[b_lane];
    end
  end

endmodule

// File: tb/tb_wb_sram_asym_dp.sv
// Directed testbench for wb_sram_asym_dp (ABITS=8, LANES_LOG2=2).
// Single-transfer vectors come from a table; bursts, collisions, bypass and
// reset are hand-written sequences.
module tb_wb_sram_asym_dp;

  localparam int ABITS = 8;
  localparam int L2    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_cyc, a_stb, a_we, a_bst;
  logic [3:0]  a_sel;
  logic [7:0]  a_adr;
  logic [31:0] a_dat_w;
  logic        a_ack, a_stall;
  logic [31:0] a_dat_r;
  logic        b_cyc, b_stb, b_we, b_bst;
  logic [9:0]  b_adr;
  logic [7:0]  b_dat_w;
  logic        b_ack, b_stall;
  logic [7:0]  b_dat_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_sram_asym_dp #(.ABITS(ABITS), .LANES_LOG2(L2), .DELAY(1)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .a_cyc_i   (a_cyc),
    .a_stb_i   (a_stb),
    .a_we_i    (a_we),
    .a_bst_i   (a_bst),
    .a_sel_i   (a_sel),
    .a_adr_i   (a_adr),
    .a_dat_i   (a_dat_w),
    .a_ack_o   (a_ack),
    .a_stall_o (a_stall),
    .a_dat_o   (a_dat_r),
    .b_cyc_i   (b_cyc),
    .b_stb_i   (b_stb),
    .b_we_i    (b_we),
    .b_bst_i   (b_bst),
    .b_adr_i   (b_adr),
    .b_dat_i   (b_dat_w),
    .b_ack_o   (b_ack),
    .b_stall_o (b_stall),
    .b_dat_o   (b_dat_r)
  );

  typedef struct {
    logic        a_en;
    logic        a_we;
    logic [3:0]  a_sel;
    logic [7:0]  a_adr;
    logic [31:0] a_dat;
    logic        a_chk;
    logic [31:0] a_exp;
    logic        b_en;
    logic        b_we;
    logic [9:0]  b_adr;
    logic [7:0]  b_dat;
    logic        b_chk;
    logic [7:0]  b_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    a_cyc = 0; a_stb = 0; a_we = 0; a_bst = 0; a_sel = '0; a_adr = '0; a_dat_w = '0;
  endtask

  task automatic idle_b();
    b_cyc = 0; b_stb = 0; b_we = 0; b_bst = 0; b_adr = '0; b_dat_w = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    a_cyc = v.a_en; a_stb = v.a_en; a_we = v.a_we; a_bst = 0;
    a_sel = v.a_sel; a_adr = v.a_adr; a_dat_w = v.a_dat;
    b_cyc = v.b_en; b_stb = v.b_en; b_we = v.b_we; b_bst = 0;
    b_adr = v.b_adr; b_dat_w = v.b_dat;
    #1 check($sformatf("vec%0d b_stall", idx), 32'(b_stall), 32'd0);
    @(posedge clk);
    #1 idle_a(); idle_b();
    @(negedge clk);
    check($sformatf("vec%0d a_ack", idx), 32'(a_ack), 32'(v.a_en));
    check($sformatf("vec%0d b_ack", idx), 32'(b_ack), 32'(v.b_en));
    if (v.a_chk) check($sformatf("vec%0d a_dat", idx), a_dat_r, v.a_exp);
    if (v.b_chk) check($sformatf("vec%0d b_dat", idx), 32'(b_dat_r), 32'(v.b_exp));
  endtask

  // Single read on port A, used to confirm contents after sequences.
  task automatic read_a(input logic [7:0] adr, input logic [31:0] exp,
                        input string name);
    vec_t v;
    v = '{1'b1, 1'b0, 4'h0, adr, 32'h0, 1'b1, exp,
          1'b0, 1'b0, 10'h0, 8'h0, 1'b0, 8'h0};
    run_vec(v, 999);
    check(name, a_dat_r, exp);
  endtask

  initial begin
    logic [7:0] bexp [4];
    logic [7:0] byp_exp;
    bexp = '{8'h33, 8'h44, 8'h55, 8'h66};
`ifdef WB_SRAM_ASYM_BYPASS_EN
    byp_exp = 8'hFF;
`else
    byp_exp = 8'h11;
`endif

    //            a_en a_we sel   adr    dat           chk  exp            b_en b_we adr     dat    chk  exp
    vecs.push_back('{1,1, 4'hF, 8'h10, 32'hAABBCCDD, 0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,1, 4'h5, 8'h10, 32'h11223344, 0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,0, 4'h0, 8'h10, 32'h0,        1, 32'hAA22CC44,  0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{0,0, 4'h0, 8'h00, 32'h0,        0, 32'h0,         1,0, 10'h040, 8'h00, 1, 8'h44});
    vecs.push_back('{0,0, 4'h0, 8'h00, 32'h0,        0, 32'h0,         1,0, 10'h041, 8'h00, 1, 8'hCC});
    vecs.push_back('{0,0, 4'h0, 8'h00, 32'h0,        0, 32'h0,         1,0, 10'h042, 8'h00, 1, 8'h22});
    vecs.push_back('{0,0, 4'h0, 8'h00, 32'h0,        0, 32'h0,         1,0, 10'h043, 8'h00, 1, 8'hAA});
    vecs.push_back('{1,1, 4'h0, 8'h10, 32'h0,        0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,0, 4'h0, 8'h10, 32'h0,        1, 32'hAA22CC44,  0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{0,0, 4'h0, 8'h00, 32'h0,        0, 32'h0,         1,1, 10'h041, 8'h5A, 0, 8'h00});
    vecs.push_back('{1,0, 4'h0, 8'h10, 32'h0,        1, 32'hAA225A44,  0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,1, 4'hF, 8'h10, 32'hFFFFFFFF, 1, 32'hAA225A44,  0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,0, 4'h0, 8'h10, 32'h0,        1, 32'hFFFFFFFF,  0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,1, 4'hF, 8'h30, 32'h01020304, 0, 32'h0,         1,1, 10'h043, 8'h77, 0, 8'h00});
    vecs.push_back('{1,0, 4'h0, 8'h10, 32'h0,        1, 32'h77FFFFFF,  1,0, 10'h0C2, 8'h00, 1, 8'h02});
    vecs.push_back('{1,1, 4'hF, 8'h20, 32'h00000000, 0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,1, 4'hF, 8'h05, 32'h00000000, 0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,1, 4'hF, 8'h06, 32'h12345678, 0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,1, 4'hF, 8'hFF, 32'h44332211, 0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,1, 4'hF, 8'h00, 32'h88776655, 0, 32'h0,         0,0, 10'h000, 8'h00, 0, 8'h00});
    vecs.push_back('{1,0, 4'h0, 8'h05, 32'h0,        1, 32'h00000000,  1,0, 10'h019, 8'h00, 1, 8'h56});

    // Reset state
    idle_a(); idle_b();
    rst_n = 1'b0;
    #12;
    check("reset a_ack", 32'(a_ack), 32'd0);
    check("reset b_ack", 32'(b_ack), 32'd0);
    check("reset a_dat", a_dat_r, 32'd0);
    check("reset b_dat", 32'(b_dat_r), 32'd0);
    check("reset a_stall", 32'(a_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // B burst across the top of the byte space; adr is scrambled after the
    // first accept to show the counter is used.
    @(negedge clk);
    b_cyc = 1; b_stb = 1; b_we = 0; b_bst = 1; b_adr = 10'h3FE;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 b_adr = 10'h123;
      b_bst = (k < 1) ? 1'b1 : ((k < 2) ? 1'b1 : 1'b0);
      if (k == 3) idle_b();
      @(negedge clk);
      check($sformatf("burst%0d b_ack", k), 32'(b_ack), 32'd1);
      check($sformatf("burst%0d b_dat", k), 32'(b_dat_r), 32'(bexp[k]));
    end
    @(negedge clk);
    check("burst end b_ack", 32'(b_ack), 32'd0);

    // Collision on word 0x20 lane 1; A drops cyc right after its accept.
    @(negedge clk);
    a_cyc = 1; a_stb = 1; a_we = 1; a_sel = 4'b0010; a_adr = 8'h20; a_dat_w = 32'h0000AB00;
    b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 10'h081; b_dat_w = 8'hCD;
    #1 check("coll b_stall", 32'(b_stall), 32'd1);
    @(posedge clk);
    #1 idle_a();
    @(negedge clk);
    check("coll a_ack", 32'(a_ack), 32'd1);
    check("coll b_ack early", 32'(b_ack), 32'd0);
    check("coll b_stall clear", 32'(b_stall), 32'd0);
    @(posedge clk);
    #1 idle_b();
    @(negedge clk);
    check("coll b_ack", 32'(b_ack), 32'd1);
    check("coll a_ack end", 32'(a_ack), 32'd0);
    read_a(8'h20, 32'h0000CD00, "coll word");

    // Same word, disjoint lanes: no stall, both written.
    @(negedge clk);
    a_cyc = 1; a_stb = 1; a_we = 1; a_sel = 4'b0001; a_adr = 8'h20; a_dat_w = 32'h00000011;
    b_cyc = 1; b_stb = 1; b_we = 1; b_adr = 10'h082; b_dat_w = 8'h22;
    #1 check("disj b_stall", 32'(b_stall), 32'd0);
    @(posedge clk);
    #1 idle_a(); idle_b();
    @(negedge clk);
    check("disj a_ack", 32'(a_ack), 32'd1);
    check("disj b_ack", 32'(b_ack), 32'd1);
    read_a(8'h20, 32'h0022CD11, "disj word");

    // Cross-port read of a byte written in the same cycle.
    @(negedge clk);
    a_cyc = 1; a_stb = 1; a_we = 1; a_sel = 4'b0001; a_adr = 8'h20; a_dat_w = 32'h000000FF;
    b_cyc = 1; b_stb = 1; b_we = 0; b_adr = 10'h080;
    @(posedge clk);
    #1 idle_a(); idle_b();
    @(negedge clk);
    check("bypass b_ack", 32'(b_ack), 32'd1);
    check("bypass b_dat", 32'(b_dat_r), 32'(byp_exp));
    read_a(8'h20, 32'h0022CDFF, "bypass word");

    // Reset in the middle of an A burst.
    @(negedge clk);
    a_cyc = 1; a_stb = 1; a_we = 0; a_bst = 1; a_adr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    check("rstb a_ack", 32'(a_ack), 32'd1);
    check("rstb a_dat", a_dat_r, 32'h77FFFFFF);
    rst_n = 1'b0;
    #1;
    check("rstb ack drop", 32'(a_ack), 32'd0);
    check("rstb dat clear", a_dat_r, 32'd0);
    @(negedge clk);
    check("rstb ack held", 32'(a_ack), 32'd0);
    rst_n = 1'b1; a_bst = 0; a_adr = 8'h05;
    @(posedge clk);
    #1 idle_a();
    @(negedge clk);
    check("rstb post ack", 32'(a_ack), 32'd1);
    check("rstb post dat", a_dat_r, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
